baseline_tracker: RTL and testbench
===================================

# baseline_tracker

Parametrised hierarchical baseline estimator for the per-channel feature path. It decimates a stream of 1-second samples by two accumulate-and-dump stages into segment sums, such as 5 s blocks and 30 s segments. A circular history of segment sums is kept, and a scaled baseline is emitted as the sum of the oldest BASE segments. It feeds the threshold comparator and adds a `hold` freeze mode for use while a detection is active.

## Interface
- IN_W, 25: width of signed input sample
- N1, 5: input samples per level-1 block
- N2, 6: level-1 blocks per segment
- HIST, 8: segment sums retained in history (power of 2 not required, ≥ BASE)
- BASE, 4: oldest segments summed into baseline (≥1)
- SHIFT, 8: arithmetic right shift applied to baseline sum
- W1, 28: level-1 width, must be ≥ IN_W+clog2(N1)
- W2, 31: segment width, must be ≥ W1+clog2(N2)
- OUT_W, 33: output width, must be ≥ W2+clog2(BASE)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- din  in  IN_W  signed sample
- din_valid  in  1  one-cycle strobe, din sampled when high
- hold  in  1  when high, din_valid is ignored (baseline frozen)
- dout  out  OUT_W  signed baseline, held between updates
- dout_valid  out  1  one-cycle pulse on each new dout
- baseline_ready  out  1  high from first dout_valid until rst

## Operation
- Accepted sample = din_valid & ~hold.
- Level 1: acc1 += din (sign-extended to W1), counter c1 0..N1-1. On accepted sample with c1==N1-1: blk <= acc1+din, blk_valid <= 1 for one cycle; acc1, c1 <= 0.
- Level 2: same scheme on blk_valid with acc2 (W2), c2 0..N2-1; emits seg, seg_valid (one cycle).
- History: HIST-entry array, write pointer wp (wraps HIST-1→0), fill counter saturating at HIST. On seg_valid: mem[wp] <= seg, wp advances, fill increments.
- Baseline FSM: IDLE, SUM, OUT.
  - IDLE→SUM on the seg_valid edge where fill reaches (or is already) HIST. Captures rp = post-write wp (oldest entry), k=0, sum=0.
  - SUM: each cycle sum += sign-extended mem[(rp+k) mod HIST], k++. After the k==BASE-1 add → OUT.
  - OUT: dout <= sum >>> SHIFT, dout_valid <= 1, baseline_ready <= 1, → IDLE.
- Result: baseline = oldest BASE of the last HIST segments. Each new segment slides the window by one segment.
- hold does not affect a summation already in progress. Partial accumulators are retained across hold.
- Elaboration check: N1*N2 ≥ BASE+3, so that a new segment cannot arrive while not IDLE. Also BASE ≤ HIST.
- No saturation. The width rules above guarantee no overflow.

## Timing
- Reset values: dout=0, dout_valid=0, baseline_ready=0. Also acc1, acc2, c1, c2, wp, fill, sum, k = 0, and FSM=IDLE. History contents are don't-care (gated by fill).
- rst mid-operation (any state, including SUM) aborts all activity. A full HIST*N1*N2 accepted samples is needed before the next dout_valid.
- Latency: edge E0 samples the final accepted sample of a segment. blk_valid is high after E0, seg_valid after E1, and the write happens at E2. SUM runs over BASE edges. dout_valid is high in the cycle after edge E2+BASE+1, which is BASE+3 cycles after E0 (7 at defaults).
- din_valid may be asserted every cycle. There is no backpressure.
- rst and din_valid on the same edge: rst wins and the sample is dropped.
- hold and din_valid on the same edge: sample dropped, counters unchanged.
- Wrap-around: rp+k is computed modulo HIST and is correct for any rp.

## Test plan
- Constant din=256, din_valid every cycle, defaults: first dout_valid exactly 7 cycles after the 240th sample edge, dout=120 (30720>>>8), baseline_ready rises with it. No dout_valid before that.
- Constant din=-512: dout=-240 (arithmetic shift, sign preserved through all widths).
- Segment k (k=1..10) uses din=k*256 for all 30 samples: outputs after segments 8, 9, 10 are 300, 420, 540. This exercises sliding and wp wrap.
- hold high for 50 din_valid strobes mid-segment 3, same data as the constant din=256 case: dout values unchanged, every dout_valid delayed by exactly 50 strobe-times.
- rst asserted at sample 100, and also asserted during the SUM state: all outputs 0 the next cycle. The first new dout_valid comes 240 samples after rst release.
- Sparse din_valid (every 3rd cycle) with N1=2, N2=3, HIST=3, BASE=2, SHIFT=0, din=1: dout=12 after 18 samples, i.e. 12 = 2 segments × 6 samples per segment, consistent with the N1*N2 ≥ BASE+3 constraint.

Source files
------------

// File: rtl/baseline_tracker.sv
`default_nettype none
// ============================================================================
// Module   : baseline_tracker
// Brief    : Two-stage accumulate-and-dump decimator feeding a circular
//            history of segment sums; emits the scaled sum of the oldest
//            BASE segments of the last HIST as a per-channel baseline.
//            A hold input freezes sample intake while a detection is active.
// Revision : 1.0 - initial release
// ============================================================================
module baseline_tracker #(
  parameter int IN_W  = 25,
  parameter int N1    = 5,
  parameter int N2    = 6,
  parameter int HIST  = 8,
  parameter int BASE  = 4,
  parameter int SHIFT = 8,
  parameter int W1    = 28,
  parameter int W2    = 31,
  parameter int OUT_W = 33
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [IN_W-1:0]  din,
  input  logic                    din_valid,
  input  logic                    hold,
  output logic signed [OUT_W-1:0] dout,
  output logic                    dout_valid,
  output logic                    baseline_ready
);

  localparam int c_c1_w   = (N1 > 1) ? $clog2(N1) : 1;
  localparam int c_c2_w   = (N2 > 1) ? $clog2(N2) : 1;
  localparam int c_ptr_w  = (HIST > 1) ? $clog2(HIST) : 1;
  localparam int c_fill_w = $clog2(HIST + 1);
  localparam int c_k_w    = (BASE > 1) ? $clog2(BASE) : 1;

  localparam logic [c_c1_w-1:0]   c_c1_last  = c_c1_w'(N1 - 1);
  localparam logic [c_c2_w-1:0]   c_c2_last  = c_c2_w'(N2 - 1);
  localparam logic [c_ptr_w-1:0]  c_wp_last  = c_ptr_w'(HIST - 1);
  localparam logic [c_fill_w-1:0] c_fill_max = c_fill_w'(HIST);
  localparam logic [c_fill_w-1:0] c_fill_pre = c_fill_w'(HIST - 1);
  localparam logic [c_k_w-1:0]    c_k_last   = c_k_w'(BASE - 1);
  localparam logic [c_ptr_w:0]    c_hist_ext = (c_ptr_w + 1)'(HIST);

  // Parameter sanity: a segment must never arrive while a summation runs,
  // and the accumulator widths must cover their worst-case growth.
  generate
    if (N1 * N2 < BASE + 3) begin : g_chk_rate
      $error("baseline_tracker: N1*N2 must be >= BASE+3");
    end
    if (BASE < 1 || BASE > HIST) begin : g_chk_base
      $error("baseline_tracker: BASE must satisfy 1 <= BASE <= HIST");
    end
    if (W1 < IN_W + $clog2(N1) || W2 < W1 + $clog2(N2) ||
        OUT_W < W2 + $clog2(BASE)) begin : g_chk_width
      $error("baseline_tracker: accumulator widths too narrow");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SUM  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  logic                   w_accept;
  logic signed [W1-1:0]   w_din_ext;
  logic signed [W1-1:0]   r_acc1;
  logic signed [W1-1:0]   r_blk;
  logic [c_c1_w-1:0]      r_c1;
  logic                   r_blk_valid;

  logic signed [W2-1:0]   w_blk_ext;
  logic signed [W2-1:0]   r_acc2;
  logic signed [W2-1:0]   r_seg;
  logic [c_c2_w-1:0]      r_c2;
  logic                   r_seg_valid;

  logic signed [W2-1:0]   r_mem [HIST];
  logic [c_ptr_w-1:0]     r_wp;
  logic [c_ptr_w-1:0]     w_wp_next;
  logic [c_fill_w-1:0]    r_fill;
  logic                   w_full;

  state_t                 r_state;
  state_t                 w_state_next;
  logic                   w_start;
  logic [c_ptr_w-1:0]     r_rp;
  logic [c_k_w-1:0]       r_k;
  logic [c_ptr_w:0]       w_idx_sum;
  logic [c_ptr_w-1:0]     w_rd_idx;
  logic signed [W2-1:0]   w_rd_data;
  logic signed [OUT_W-1:0] r_sum;

  assign w_accept  = din_valid & ~hold;
  assign w_din_ext = W1'(din);
  assign w_blk_ext = W2'(r_blk);

  // Level 1: accumulate N1 accepted samples, dump the block sum
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc1      <= '0;
      r_blk       <= '0;
      r_c1        <= '0;
      r_blk_valid <= 1'b0;
    end else begin
      r_blk_valid <= 1'b0;
      if (w_accept) begin
        if (r_c1 == c_c1_last) begin
          r_blk       <= r_acc1 + w_din_ext;
          r_blk_valid <= 1'b1;
          r_acc1      <= '0;
          r_c1        <= '0;
        end else begin
          r_acc1 <= r_acc1 + w_din_ext;
          r_c1   <= r_c1 + 1'b1;
        end
      end
    end
  end

  // Level 2: accumulate N2 block sums, dump the segment sum
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc2      <= '0;
      r_seg       <= '0;
      r_c2        <= '0;
      r_seg_valid <= 1'b0;
    end else begin
      r_seg_valid <= 1'b0;
      if (r_blk_valid) begin
        if (r_c2 == c_c2_last) begin
          r_seg       <= r_acc2 + w_blk_ext;
          r_seg_valid <= 1'b1;
          r_acc2      <= '0;
          r_c2        <= '0;
        end else begin
          r_acc2 <= r_acc2 + w_blk_ext;
          r_c2   <= r_c2 + 1'b1;
        end
      end
    end
  end

  assign w_wp_next = (r_wp == c_wp_last) ? '0 : r_wp + 1'b1;
  // Full once this write lands: the fill count is at or beyond HIST-1
  assign w_full    = (r_fill >= c_fill_pre);

  // History storage; contents are only read once fill covers them
  always_ff @(posedge clk) begin
    if (r_seg_valid) begin
      r_mem[r_wp] <= r_seg;
    end
  end

  // Write pointer and saturating fill count
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp   <= '0;
      r_fill <= '0;
    end else if (r_seg_valid) begin
      r_wp <= w_wp_next;
      if (r_fill != c_fill_max) begin
        r_fill <= r_fill + 1'b1;
      end
    end
  end

  // Read index (rp + k) mod HIST; rp < HIST and k < BASE <= HIST, so one
  // conditional subtraction suffices for any HIST
  assign w_idx_sum = {1'b0, r_rp} + (c_ptr_w + 1)'(r_k);
  assign w_rd_idx  = (w_idx_sum >= c_hist_ext) ? c_ptr_w'(w_idx_sum - c_hist_ext)
                                               : w_idx_sum[c_ptr_w-1:0];
  assign w_rd_data = r_mem[w_rd_idx];

  // Baseline FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Baseline FSM next-state: start on a segment write that fills history
  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_seg_valid && w_full) begin
          w_state_next = S_SUM;
          w_start      = 1'b1;
        end
      end
      S_SUM: begin
        if (r_k == c_k_last) begin
          w_state_next = S_OUT;
        end
      end
      S_OUT:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Summation datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rp           <= '0;
      r_k            <= '0;
      r_sum          <= '0;
      dout           <= '0;
      dout_valid     <= 1'b0;
      baseline_ready <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_rp  <= w_wp_next;
            r_k   <= '0;
            r_sum <= '0;
          end
        end
        S_SUM: begin
          r_sum <= r_sum + OUT_W'(w_rd_data);
          r_k   <= r_k + 1'b1;
        end
        S_OUT: begin
          dout           <= r_sum >>> SHIFT;
          dout_valid     <= 1'b1;
          baseline_ready <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_baseline_tracker.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_baseline_tracker
// Brief    : Self-checking bench for baseline_tracker; a segment-level
//            reference model predicts every output cycle and value.
// Revision : 1.0 - initial release
// ============================================================================
module tb_baseline_tracker;

  localparam int IN_W    = 25;
  localparam int OUT_W   = 33;
  localparam int SEG_LEN = 30;
  localparam int HIST    = 8;
  localparam int BASE    = 4;
  localparam int SHIFT   = 8;
  localparam int LAT     = BASE + 3;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic signed [IN_W-1:0]  din = '0;
  logic                    din_valid = 1'b0;
  logic                    hold = 1'b0;
  logic signed [OUT_W-1:0] dout;
  logic                    dout_valid;
  logic                    baseline_ready;

  logic signed [IN_W-1:0]  din2 = '0;
  logic                    din_valid2 = 1'b0;
  logic                    hold2 = 1'b0;
  logic signed [28:0]      dout2;
  logic                    dout_valid2;
  logic                    baseline_ready2;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model state: sample-level segment sums and pending outputs
  int      seg_cnt;
  longint  seg_part;
  longint  seg_hist[$];
  longint  pend_val[$];
  int      pend_due[$];
  bit      exp_valid;
  bit      exp_ready;
  longint  exp_dout;

  always #5 clk = ~clk;

  baseline_tracker u_dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .hold(hold),
    .dout(dout), .dout_valid(dout_valid), .baseline_ready(baseline_ready)
  );

  baseline_tracker #(
    .IN_W(25), .N1(2), .N2(3), .HIST(3), .BASE(2), .SHIFT(0),
    .W1(26), .W2(28), .OUT_W(29)
  ) u_dut_sparse (
    .clk(clk), .rst(rst), .din(din2), .din_valid(din_valid2), .hold(hold2),
    .dout(dout2), .dout_valid(dout_valid2), .baseline_ready(baseline_ready2)
  );

  // One clock edge: update the model with the inputs seen at this edge
  task automatic tick();
    longint s;
    @(posedge clk);
    cyc++;
    exp_valid = 1'b0;
    if (rst) begin
      seg_cnt = 0; seg_part = 0; seg_hist.delete();
      pend_val.delete(); pend_due.delete();
      exp_ready = 1'b0; exp_dout = 0;
    end else begin
      if (din_valid && !hold) begin
        seg_part += longint'(din);
        seg_cnt++;
        if (seg_cnt == SEG_LEN) begin
          seg_hist.push_back(seg_part);
          seg_part = 0;
          seg_cnt  = 0;
          if (seg_hist.size() > HIST) void'(seg_hist.pop_front());
          if (seg_hist.size() == HIST) begin
            s = 0;
            for (int i = 0; i < BASE; i++) s += seg_hist[i];
            pend_val.push_back(s >>> SHIFT);
            pend_due.push_back(cyc + LAT);
          end
        end
      end
      if (pend_due.size() > 0 && pend_due[0] == cyc) begin
        exp_valid = 1'b1;
        exp_ready = 1'b1;
        exp_dout  = pend_val.pop_front();
        void'(pend_due.pop_front());
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; din_valid = 1'b0; hold = 1'b0; din = '0;
    din_valid2 = 1'b0; hold2 = 1'b0; din2 = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; din_valid = 1'b1; din = 25'sd123;
    tick();
    checks++;
    if (dout !== '0 || dout_valid !== 1'b0 || baseline_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: dout=%0d valid=%b ready=%b, required 0/0/0", dout, dout_valid, baseline_ready);
    end
    do_reset();
    checks++;
    if (dout !== '0 || dout_valid !== 1'b0 || baseline_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: dout=%0d valid=%b ready=%b, required 0/0/0", dout, dout_valid, baseline_ready);
    end
  endtask

  task automatic test_constant(input logic signed [IN_W-1:0] val, input longint want);
    int t0, first;
    longint first_val;
    do_reset();
    t0 = cyc; first = -1; first_val = 0;
    din = val; din_valid = 1'b1; hold = 1'b0;
    for (int i = 0; i < 260; i++) begin
      tick();
      checks++;
      if (dout_valid !== exp_valid || baseline_ready !== exp_ready || dout !== OUT_W'(exp_dout)) begin
        failures++;
        $display("FAIL constant_model cyc=%0d: valid=%b ready=%b dout=%0d, required %b/%b/%0d", cyc, dout_valid, baseline_ready, dout, exp_valid, exp_ready, exp_dout);
      end
      if (dout_valid === 1'b1 && first < 0) begin first = cyc; first_val = longint'(dout); end
    end
    din_valid = 1'b0;
    checks++;
    if (first != t0 + 240 + 7) begin
      failures++;
      $display("FAIL constant_latency: first dout_valid at cycle offset %0d, required %0d", first - t0, 247);
    end
    checks++;
    if (first_val != want) begin
      failures++;
      $display("FAIL constant_value: dout=%0d, required %0d", first_val, want);
    end
  endtask

  task automatic test_sliding();
    longint obs[$];
    longint want[3];
    want[0] = 300; want[1] = 420; want[2] = 540;
    do_reset();
    din_valid = 1'b1; hold = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      din = IN_W'(k * 256);
      for (int i = 0; i < SEG_LEN; i++) begin
        tick();
        checks++;
        if (dout_valid !== exp_valid || baseline_ready !== exp_ready || dout !== OUT_W'(exp_dout)) begin
          failures++;
          $display("FAIL sliding_model cyc=%0d: valid=%b dout=%0d, required %b/%0d", cyc, dout_valid, dout, exp_valid, exp_dout);
        end
        if (dout_valid === 1'b1) obs.push_back(longint'(dout));
      end
    end
    din_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (dout_valid === 1'b1) obs.push_back(longint'(dout));
    end
    checks++;
    if (obs.size() != 3) begin
      failures++;
      $display("FAIL sliding_count: %0d outputs, required 3", obs.size());
    end
    for (int i = 0; i < 3 && i < obs.size(); i++) begin
      checks++;
      if (obs[i] != want[i]) begin
        failures++;
        $display("FAIL sliding_value[%0d]: dout=%0d, required %0d", i, obs[i], want[i]);
      end
    end
  endtask

  task automatic test_hold();
    int t0, first;
    longint first_val;
    do_reset();
    t0 = cyc; first = -1; first_val = 0;
    din = 25'sd256; din_valid = 1'b1;
    for (int i = 1; i <= 310; i++) begin
      hold = (i > 70 && i <= 120);
      tick();
      checks++;
      if (dout_valid !== exp_valid || baseline_ready !== exp_ready || dout !== OUT_W'(exp_dout)) begin
        failures++;
        $display("FAIL hold_model cyc=%0d: valid=%b dout=%0d, required %b/%0d", cyc, dout_valid, dout, exp_valid, exp_dout);
      end
      if (dout_valid === 1'b1 && first < 0) begin first = cyc; first_val = longint'(dout); end
    end
    hold = 1'b0; din_valid = 1'b0;
    checks++;
    if (first != t0 + 297 || first_val != 120) begin
      failures++;
      $display("FAIL hold_delay: first output offset %0d value %0d, required offset 297 value 120", first - t0, first_val);
    end
  endtask

  task automatic test_rst_mid();
    int t0, first, seen;
    do_reset();
    din = 25'sd256; din_valid = 1'b1;
    for (int i = 0; i < 99; i++) tick();
    rst = 1'b1;
    tick();
    checks++;
    if (dout !== '0 || dout_valid !== 1'b0 || baseline_ready !== 1'b0) begin
      failures++;
      $display("FAIL rst_sample100: dout=%0d valid=%b ready=%b, required 0/0/0", dout, dout_valid, baseline_ready);
    end
    rst = 1'b0;
    t0 = cyc; first = -1;
    for (int i = 0; i < 250; i++) begin
      tick();
      checks++;
      if (dout_valid !== exp_valid || baseline_ready !== exp_ready || dout !== OUT_W'(exp_dout)) begin
        failures++;
        $display("FAIL rst_model cyc=%0d: valid=%b dout=%0d, required %b/%0d", cyc, dout_valid, dout, exp_valid, exp_dout);
      end
      if (dout_valid === 1'b1 && first < 0) first = cyc;
    end
    checks++;
    if (first != t0 + 247) begin
      failures++;
      $display("FAIL rst_recover: first output offset %0d, required 247", first - t0);
    end
    // Abort during summation: reset lands four edges after the last sample
    do_reset();
    din_valid = 1'b1;
    for (int i = 0; i < 240; i++) tick();
    din_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b1;
    tick();
    checks++;
    if (dout !== '0 || dout_valid !== 1'b0 || baseline_ready !== 1'b0) begin
      failures++;
      $display("FAIL rst_in_sum: dout=%0d valid=%b ready=%b, required 0/0/0", dout, dout_valid, baseline_ready);
    end
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (dout_valid !== 1'b0 || baseline_ready !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL rst_in_sum_quiet: %0d cycles with activity, required 0", seen);
    end
  endtask

  task automatic test_random();
    int n_out;
    do_reset();
    n_out = 0;
    for (int i = 0; i < 4000; i++) begin
      din       = IN_W'(int'($urandom_range(0, 2097152)) - 1048576);
      din_valid = ($urandom_range(0, 9) < 7);
      hold      = ($urandom_range(0, 9) == 0);
      rst       = ($urandom_range(0, 1999) == 0);
      tick();
      checks++;
      if (dout_valid !== exp_valid || baseline_ready !== exp_ready || dout !== OUT_W'(exp_dout)) begin
        failures++;
        $display("FAIL random_model cyc=%0d: valid=%b ready=%b dout=%0d, required %b/%b/%0d", cyc, dout_valid, baseline_ready, dout, exp_valid, exp_ready, exp_dout);
      end
      if (exp_valid) n_out++;
    end
    rst = 1'b0; din_valid = 1'b0; hold = 1'b0;
    checks++;
    if (n_out < 10) begin
      failures++;
      $display("FAIL random_coverage: %0d outputs predicted, required at least 10", n_out);
    end
  endtask

  task automatic test_sparse();
    int acc_n, n_out;
    int due_q[$];
    bit acc, exp2;
    do_reset();
    acc_n = 0; n_out = 0;
    din2 = 25'sd1;
    for (int c = 0; c < 105; c++) begin
      din_valid2 = ((c % 3) == 0) && (acc_n < 30);
      acc = din_valid2;
      tick();
      if (acc) begin
        acc_n++;
        if (acc_n % 6 == 0 && acc_n >= 18) due_q.push_back(cyc + 5);
      end
      exp2 = (due_q.size() > 0 && due_q[0] == cyc);
      if (exp2) void'(due_q.pop_front());
      checks++;
      if (dout_valid2 !== exp2) begin
        failures++;
        $display("FAIL sparse_valid cyc=%0d: valid=%b, required %b", cyc, dout_valid2, exp2);
      end
      if (exp2) begin
        n_out++;
        checks++;
        if (dout2 !== 29'sd12 || baseline_ready2 !== 1'b1) begin
          failures++;
          $display("FAIL sparse_value: dout=%0d ready=%b, required 12/1", dout2, baseline_ready2);
        end
      end
    end
    din_valid2 = 1'b0;
    checks++;
    if (n_out != 3) begin
      failures++;
      $display("FAIL sparse_count: %0d outputs, required 3", n_out);
    end
  endtask

  initial begin
    test_reset();
    test_constant(25'sd256, 120);
    test_constant(-25'sd512, -240);
    test_sliding();
    test_hold();
    test_rst_mid();
    test_random();
    test_sparse();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
